// File: rtl/cc_reorder_merge_unit.sv
// Read-return merger: replays buffered hit lines (critical word first) and MEM miss bursts onto INCT R in request order.
// Optional feature macro CC_REORDER_STATS_EN adds hit/miss return counters.
module cc_reorder_merge_unit #(
    parameter int DATA_W     = 64,
    parameter int LINE_W     = 512,
    parameter int OFS_W      = 6,
    parameter int FLAG_DEPTH = 16,
    parameter int FLAG_AFULL = 13,
    parameter int HIT_DEPTH  = 16,
    parameter int HIT_AFULL  = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       mem_rdata_i,
    input  logic                    mem_rlast_i,
    input  logic                    mem_rvalid_i,
    output logic                    mem_rready_o,
    input  logic                    flag_wren_i,
    input  logic                    flag_wdata_i,
    output logic                    flag_afull_o,
    input  logic                    hit_wren_i,
    input  logic [OFS_W+LINE_W-1:0] hit_wdata_i,
    output logic                    hit_afull_o,
    output logic [DATA_W-1:0]       inct_rdata_o,
    output logic                    inct_rlast_o,
    output logic                    inct_rvalid_o,
    input  logic                    inct_rready_i,
    output logic                    reorder_err_o
`ifdef CC_REORDER_STATS_EN
    ,
    output logic [31:0]             hit_cnt_o,
    output logic [31:0]             miss_cnt_o
`endif
);

    localparam int BEATS = LINE_W / DATA_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int BSH   = $clog2(DATA_W / 8);
    localparam int HIT_W = OFS_W + LINE_W;
    localparam int FPW   = $clog2(FLAG_DEPTH);
    localparam int FCW   = FPW + 1;
    localparam int HPW   = $clog2(HIT_DEPTH);
    localparam int HCW   = HPW + 1;

    localparam logic [CNT_W-1:0] LAST_BEAT    = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [FCW-1:0]   FLAG_FULL_C  = FCW'(FLAG_DEPTH);
    localparam logic [FCW-1:0]   FLAG_AFULL_C = FCW'(FLAG_AFULL);
    localparam logic [FCW-1:0]   FCNT_ONE     = FCW'(1);
    localparam logic [FPW-1:0]   FPTR_ONE     = FPW'(1);
    localparam logic [HCW-1:0]   HIT_FULL_C   = HCW'(HIT_DEPTH);
    localparam logic [HCW-1:0]   HIT_AFULL_C  = HCW'(HIT_AFULL);
    localparam logic [HCW-1:0]   HCNT_ONE     = HCW'(1);
    localparam logic [HPW-1:0]   HPTR_ONE     = HPW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIT  = 2'b01,
        ST_MISS = 2'b10
    } state_e;

    state_e              state_r, state_nx_s;
    logic [CNT_W-1:0]    beat_cnt_r, beat_cnt_nx_s;

    logic                flag_mem_r [FLAG_DEPTH];
    logic [FPW-1:0]      flag_wr_ptr_r, flag_rd_ptr_r;
    logic [FCW-1:0]      flag_cnt_r, flag_cnt_nx_s;
    logic                flag_afull_r;
    logic                flag_push_s, flag_pop_s, flag_full_s, flag_empty_s, flag_head_s;

    logic [HIT_W-1:0]    hit_mem_r [HIT_DEPTH];
    logic [HPW-1:0]      hit_wr_ptr_r, hit_rd_ptr_r;
    logic [HCW-1:0]      hit_cnt_r, hit_cnt_nx_s;
    logic                hit_afull_r;
    logic                hit_push_s, hit_pop_s, hit_full_s, hit_empty_s;
    logic [HIT_W-1:0]    hit_head_s;
    logic [OFS_W-1:0]    hit_ofs_s;
    logic [CNT_W-1:0]    start_s, idx_s;
    logic [DATA_W-1:0]   hit_beats_s [BEATS];
    logic                unused_ofs_s;

    logic                adv_s, accept_s, src_last_s, err_set_s, mem_rready_s;
    logic [DATA_W-1:0]   src_data_s;
    logic [DATA_W-1:0]   inct_rdata_r;
    logic                inct_rlast_r, inct_rvalid_r, reorder_err_r;

    assign flag_full_s  = (flag_cnt_r == FLAG_FULL_C);
    assign flag_empty_s = (flag_cnt_r == {FCW{1'b0}});
    assign flag_push_s  = flag_wren_i && (!flag_full_s || flag_pop_s);
    assign flag_head_s  = flag_mem_r[flag_rd_ptr_r];

    assign hit_full_s   = (hit_cnt_r == HIT_FULL_C);
    assign hit_empty_s  = (hit_cnt_r == {HCW{1'b0}});
    assign hit_push_s   = hit_wren_i && (!hit_full_s || hit_pop_s);
    assign hit_head_s   = hit_mem_r[hit_rd_ptr_r];
    assign hit_ofs_s    = hit_head_s[HIT_W-1:LINE_W];
    // Only the beat-aligned part of the byte offset selects the critical word.
    assign start_s      = hit_ofs_s[BSH +: CNT_W];
    assign unused_ofs_s = ^hit_ofs_s;
    assign idx_s        = start_s + beat_cnt_r;

    for (genvar g = 0; g < BEATS; g++) begin : g_beat
        assign hit_beats_s[g] = hit_head_s[g*DATA_W +: DATA_W];
    end

    assign adv_s = !inct_rvalid_r || inct_rready_i;

    // Flag FIFO storage write.
    always_ff @(posedge clk) begin
        if (flag_push_s) flag_mem_r[flag_wr_ptr_r] <= flag_wdata_i;
    end

    // Flag FIFO occupancy next-state.
    always_comb begin
        flag_cnt_nx_s = flag_cnt_r;
        case ({flag_push_s, flag_pop_s})
            2'b10:   flag_cnt_nx_s = flag_cnt_r + FCNT_ONE;
            2'b01:   flag_cnt_nx_s = flag_cnt_r - FCNT_ONE;
            default: flag_cnt_nx_s = flag_cnt_r;
        endcase
    end

    // Flag FIFO pointers, occupancy and almost-full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_wr_ptr_r <= {FPW{1'b0}};
            flag_rd_ptr_r <= {FPW{1'b0}};
            flag_cnt_r    <= {FCW{1'b0}};
            flag_afull_r  <= 1'b0;
        end else begin
            if (flag_push_s) flag_wr_ptr_r <= flag_wr_ptr_r + FPTR_ONE;
            if (flag_pop_s)  flag_rd_ptr_r <= flag_rd_ptr_r + FPTR_ONE;
            flag_cnt_r   <= flag_cnt_nx_s;
            flag_afull_r <= (flag_cnt_nx_s >= FLAG_AFULL_C);
        end
    end

    // Hit FIFO storage write.
    always_ff @(posedge clk) begin
        if (hit_push_s) hit_mem_r[hit_wr_ptr_r] <= hit_wdata_i;
    end

    // Hit FIFO occupancy next-state.
    always_comb begin
        hit_cnt_nx_s = hit_cnt_r;
        case ({hit_push_s, hit_pop_s})
            2'b10:   hit_cnt_nx_s = hit_cnt_r + HCNT_ONE;
            2'b01:   hit_cnt_nx_s = hit_cnt_r - HCNT_ONE;
            default: hit_cnt_nx_s = hit_cnt_r;
        endcase
    end

    // Hit FIFO pointers, occupancy and almost-full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_wr_ptr_r <= {HPW{1'b0}};
            hit_rd_ptr_r <= {HPW{1'b0}};
            hit_cnt_r    <= {HCW{1'b0}};
            hit_afull_r  <= 1'b0;
        end else begin
            if (hit_push_s) hit_wr_ptr_r <= hit_wr_ptr_r + HPTR_ONE;
            if (hit_pop_s)  hit_rd_ptr_r <= hit_rd_ptr_r + HPTR_ONE;
            hit_cnt_r   <= hit_cnt_nx_s;
            hit_afull_r <= (hit_cnt_nx_s >= HIT_AFULL_C);
        end
    end

    // Source selection, beat acceptance and FIFO pops per request type.
    always_comb begin
        state_nx_s    = state_r;
        beat_cnt_nx_s = beat_cnt_r;
        accept_s      = 1'b0;
        src_data_s    = {DATA_W{1'b0}};
        src_last_s    = 1'b0;
        flag_pop_s    = 1'b0;
        hit_pop_s     = 1'b0;
        mem_rready_s  = 1'b0;
        err_set_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                beat_cnt_nx_s = {CNT_W{1'b0}};
                if (!flag_empty_s) begin
                    state_nx_s = flag_head_s ? ST_HIT : ST_MISS;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_HIT: begin
                src_data_s = hit_beats_s[idx_s];
                src_last_s = (beat_cnt_r == LAST_BEAT);
                if (!hit_empty_s && adv_s) begin
                    accept_s      = 1'b1;
                    beat_cnt_nx_s = beat_cnt_r + CNT_ONE;
                    if (src_last_s) begin
                        hit_pop_s  = 1'b1;
                        flag_pop_s = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_HIT;
                    end
                end else begin
                    state_nx_s = ST_HIT;
                end
            end
            ST_MISS: begin
                mem_rready_s = adv_s;
                src_data_s   = mem_rdata_i;
                src_last_s   = mem_rlast_i;
                if (mem_rvalid_i && adv_s) begin
                    accept_s      = 1'b1;
                    beat_cnt_nx_s = beat_cnt_r + CNT_ONE;
                    // Early or missing rlast; the burst still ends on rlast.
                    err_set_s     = mem_rlast_i ^ (beat_cnt_r == LAST_BEAT);
                    if (mem_rlast_i) begin
                        flag_pop_s = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_MISS;
                    end
                end else begin
                    state_nx_s = ST_MISS;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, beat counter, output register stage and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            beat_cnt_r    <= {CNT_W{1'b0}};
            inct_rdata_r  <= {DATA_W{1'b0}};
            inct_rlast_r  <= 1'b0;
            inct_rvalid_r <= 1'b0;
            reorder_err_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            beat_cnt_r <= beat_cnt_nx_s;
            if (accept_s) begin
                inct_rdata_r  <= src_data_s;
                inct_rlast_r  <= src_last_s;
                inct_rvalid_r <= 1'b1;
            end else if (inct_rready_i) begin
                inct_rvalid_r <= 1'b0;
            end
            if (err_set_s) reorder_err_r <= 1'b1;
        end
    end

`ifdef CC_REORDER_STATS_EN
    logic [31:0] hit_ret_cnt_r, miss_ret_cnt_r;

    // Return counters, stepped on each completed request.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_ret_cnt_r  <= 32'd0;
            miss_ret_cnt_r <= 32'd0;
        end else if (flag_pop_s) begin
            if (flag_head_s) hit_ret_cnt_r  <= hit_ret_cnt_r + 32'd1;
            else             miss_ret_cnt_r <= miss_ret_cnt_r + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_ret_cnt_r;
    assign miss_cnt_o = miss_ret_cnt_r;
`endif

    assign mem_rready_o  = mem_rready_s;
    assign flag_afull_o  = flag_afull_r;
    assign hit_afull_o   = hit_afull_r;
    assign inct_rdata_o  = inct_rdata_r;
    assign inct_rlast_o  = inct_rlast_r;
    assign inct_rvalid_o = inct_rvalid_r;
    assign reorder_err_o = reorder_err_r;

endmodule

// File: tb/tb_cc_reorder_merge_unit.sv
// Directed bench for cc_reorder_merge_unit: hit/miss ordering, critical-word wrap, backpressure, length error, afull, reset.
module tb_cc_reorder_merge_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  mem_rdata_i;
    logic         mem_rlast_i, mem_rvalid_i, mem_rready_o;
    logic         flag_wren_i, flag_wdata_i, flag_afull_o;
    logic         hit_wren_i, hit_afull_o;
    logic [517:0] hit_wdata_i;
    logic [63:0]  inct_rdata_o;
    logic         inct_rlast_o, inct_rvalid_o, inct_rready_i;
    logic         reorder_err_o;

    int errors = 0;
    int checks = 0;
    logic [64:0] mem_q[$];
    logic [64:0] got_q[$];
    logic [64:0] exp_q[$];
    logic        tog = 1'b0;
    logic        stall_prev = 1'b0;
    logic [63:0] held;

    cc_reorder_merge_unit dut (
        .clk(clk), .rst(rst),
        .mem_rdata_i(mem_rdata_i), .mem_rlast_i(mem_rlast_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o),
        .flag_wren_i(flag_wren_i), .flag_wdata_i(flag_wdata_i), .flag_afull_o(flag_afull_o),
        .hit_wren_i(hit_wren_i), .hit_wdata_i(hit_wdata_i), .hit_afull_o(hit_afull_o),
        .inct_rdata_o(inct_rdata_o), .inct_rlast_o(inct_rlast_o),
        .inct_rvalid_o(inct_rvalid_o), .inct_rready_i(inct_rready_i),
        .reorder_err_o(reorder_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] hb(input int id, input int b);
        return {8'hC0, 8'(id), 40'h0, 8'(b)};
    endfunction

    function automatic logic [63:0] mb(input int id, input int b);
        return {8'hEE, 8'(id), 40'h0, 8'(b)};
    endfunction

    function automatic logic [511:0] mk_line(input int id);
        logic [511:0] l;
        l = 512'h0;
        for (int b = 0; b < 8; b++) l[b*64 +: 64] = hb(id, b);
        return l;
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes, advance, drive the next inputs.
    task automatic cycle();
        if (stall_prev) chk("hold_data", 65'(inct_rdata_o), 65'(held));
        stall_prev = inct_rvalid_o && !inct_rready_i;
        held = inct_rdata_o;
        if (inct_rvalid_o && inct_rready_i) got_q.push_back({inct_rlast_o, inct_rdata_o});
        if (mem_rvalid_i && mem_rready_o) void'(mem_q.pop_front());
        @(posedge clk);
        #1;
        if (mem_q.size() != 0) begin
            mem_rvalid_i = 1'b1;
            {mem_rlast_i, mem_rdata_i} = mem_q[0];
        end else begin
            mem_rvalid_i = 1'b0;
            {mem_rlast_i, mem_rdata_i} = 65'h0;
        end
        inct_rready_i = tog ? ~inct_rready_i : 1'b1;
        #1;
    endtask

    task automatic push(input logic df, input logic f, input logic dh, input logic [5:0] ofs, input int id);
        flag_wren_i = df;
        flag_wdata_i = f;
        hit_wren_i = dh;
        hit_wdata_i = {ofs, mk_line(id)};
        cycle();
        flag_wren_i = 1'b0;
        hit_wren_i = 1'b0;
    endtask

    task automatic exp_hit(input int id, input int start);
        for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7), hb(id, (start + k) % 8)});
    endtask

    task automatic exp_miss(input int id, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back({(k == n - 1), mb(id, k)});
    endtask

    task automatic load_miss(input int id, input int n);
        for (int k = 0; k < n; k++) mem_q.push_back({(k == n - 1), mb(id, k)});
    endtask

    task automatic drain(input string tag);
        int n;
        int c;
        n = exp_q.size();
        c = 0;
        while (got_q.size() < n && c < 300) begin
            cycle();
            c++;
        end
        repeat (3) cycle();
        chk({tag, "_count"}, 65'(got_q.size()), 65'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) chk($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        mem_rdata_i = 64'h0; mem_rlast_i = 1'b0; mem_rvalid_i = 1'b0;
        flag_wren_i = 1'b0; flag_wdata_i = 1'b0;
        hit_wren_i = 1'b0; hit_wdata_i = 518'h0;
        inct_rready_i = 1'b1;
        repeat (3) cycle();
        chk("rst_rvalid", 65'(inct_rvalid_o), 65'h0);
        chk("rst_rlast", 65'(inct_rlast_o), 65'h0);
        chk("rst_rdata", 65'(inct_rdata_o), 65'h0);
        chk("rst_err", 65'(reorder_err_o), 65'h0);
        chk("rst_mem_rready", 65'(mem_rready_o), 65'h0);
        chk("rst_flag_afull", 65'(flag_afull_o), 65'h0);
        chk("rst_hit_afull", 65'(hit_afull_o), 65'h0);
        rst = 1'b0;

        // H,M,H with MEM data offered early.
        load_miss(1, 8);
        push(1'b1, 1'b1, 1'b1, 6'h00, 1);
        push(1'b1, 1'b0, 1'b1, 6'h00, 2);
        push(1'b1, 1'b1, 1'b0, 6'h00, 0);
        exp_hit(1, 0); exp_miss(1, 8); exp_hit(2, 0);
        drain("t1");

        // Critical word first: offset 0x18 -> start at beat 3.
        push(1'b1, 1'b1, 1'b1, 6'h18, 3);
        exp_hit(3, 3);
        drain("t2");

        // Miss at head while a hit line is buffered; second burst held off.
        load_miss(4, 8);
        load_miss(5, 8);
        push(1'b1, 1'b0, 1'b1, 6'h00, 6);
        exp_miss(4, 8);
        drain("t3a");
        repeat (3) cycle();
        chk("t3_rready_idle", 65'(mem_rready_o), 65'h0);
        chk("t3_mem_held", 65'(mem_q.size()), 65'd8);
        chk("t3_no_out", 65'(got_q.size()), 65'd0);
        push(1'b1, 1'b1, 1'b0, 6'h00, 0);
        exp_hit(6, 0);
        drain("t3b");
        push(1'b1, 1'b0, 1'b0, 6'h00, 0);
        exp_miss(5, 8);
        drain("t3c");

        // Toggling ready during a hit burst, offset 0x3F -> start at beat 7.
        tog = 1'b1;
        push(1'b1, 1'b1, 1'b1, 6'h3F, 7);
        exp_hit(7, 7);
        drain("t4");
        tog = 1'b0;
        cycle();
        chk("t4_err_clear", 65'(reorder_err_o), 65'h0);

        // Short burst: rlast on the fifth beat.
        push(1'b1, 1'b0, 1'b0, 6'h00, 0);
        load_miss(8, 5);
        exp_miss(8, 5);
        drain("t5a");
        chk("t5_err_set", 65'(reorder_err_o), 65'h1);
        push(1'b1, 1'b1, 1'b1, 6'h00, 9);
        exp_hit(9, 0);
        drain("t5b");
        chk("t5_err_sticky", 65'(reorder_err_o), 65'h1);

        // Almost-full thresholds with no drain.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6_err_reset", 65'(reorder_err_o), 65'h0);
        for (int i = 1; i <= 14; i++) begin
            push(1'b1, 1'b0, 1'b1, 6'h00, 10 + i);
            chk($sformatf("t6_flag_afull_%0d", i), 65'(flag_afull_o), 65'(i >= 13));
            chk($sformatf("t6_hit_afull_%0d", i), 65'(hit_afull_o), 65'(i >= 13));
        end

        // Reset in the middle of a miss burst.
        load_miss(30, 8);
        begin
            int c;
            c = 0;
            while (got_q.size() < 3 && c < 50) begin
                cycle();
                c++;
            end
        end
        chk("t6_midburst", 65'(got_q.size() >= 3), 65'h1);
        rst = 1'b1;
        mem_q.delete();
        mem_rvalid_i = 1'b0;
        cycle();
        chk("t6_rst_rvalid", 65'(inct_rvalid_o), 65'h0);
        chk("t6_rst_flag_afull", 65'(flag_afull_o), 65'h0);
        chk("t6_rst_hit_afull", 65'(hit_afull_o), 65'h0);
        chk("t6_rst_mem_rready", 65'(mem_rready_o), 65'h0);
        rst = 1'b0;
        got_q.delete();
        stall_prev = 1'b0;
        repeat (4) cycle();
        chk("t6_empty_no_out", 65'(got_q.size()), 65'd0);
        push(1'b1, 1'b1, 1'b1, 6'h08, 31);
        exp_hit(31, 1);
        drain("t6b");
        chk("t6_err_final", 65'(reorder_err_o), 65'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
